// File: rtl/pool_1.sv
// pool_1: binary 2x2 max-pooling (logical OR) over the 1-bit feature maps
// produced by the first convolution stage. Each window is read in four
// consecutive cycles and one result bit is written per window.
module pool_1 #(
  parameter int MAP_W   = 24,
  parameter int KERNELS = 6,
  parameter int IN_AW   = 15,
  parameter int OUT_AW  = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [IN_AW-1:0]  rd_addr,
  input  logic              rd_data,
  output logic              out_we,
  output logic [OUT_AW-1:0] out_addr,
  output logic              out_din
);

  localparam int HALF = MAP_W / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int KW   = (KERNELS > 1) ? $clog2(KERNELS) : 1;

  localparam logic [CW-1:0]    C_LAST   = CW'(HALF - 1);
  localparam logic [KW-1:0]    K_LAST   = KW'(KERNELS - 1);
  localparam logic [IN_AW-1:0] STEP_COL = IN_AW'(2);
  localparam logic [IN_AW-1:0] STEP_ROW = IN_AW'(MAP_W + 2);
  localparam logic [IN_AW-1:0] ROW_OFS  = IN_AW'(MAP_W);
  localparam logic [IN_AW-1:0] ONE_IN   = IN_AW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t              state;
  logic [2:0]          phase;
  logic [KW-1:0]       k;
  logic [CW-1:0]       r;
  logic [CW-1:0]       c;
  logic [IN_AW-1:0]    base;
  logic [IN_AW-1:0]    next_base;
  logic [OUT_AW-1:0]   wr_idx;
  logic                acc;
  logic                col_wrap;
  logic                row_wrap;
  logic                last_win;

  // Window position flags and the next window's base address. A map wrap
  // uses the same step as a row wrap: the last window of a map ends one row
  // short, and the +MAP_W+2 step lands exactly on the next map's origin.
  always_comb begin
    col_wrap  = (c == C_LAST);
    row_wrap  = col_wrap && (r == C_LAST);
    last_win  = row_wrap && (k == K_LAST);
    next_base = col_wrap ? (base + STEP_ROW) : (base + STEP_COL);
  end

  // Control FSM, window walk, OR accumulation and registered RAM ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      phase    <= '0;
      k        <= '0;
      r        <= '0;
      c        <= '0;
      base     <= '0;
      wr_idx   <= '0;
      acc      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      out_we   <= 1'b0;
      out_addr <= '0;
      out_din  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done   <= 1'b0;
          out_we <= 1'b0;
          if (start) begin
            state   <= S_RUN;
            busy    <= 1'b1;
            phase   <= '0;
            k       <= '0;
            r       <= '0;
            c       <= '0;
            base    <= '0;
            wr_idx  <= '0;
            acc     <= 1'b0;
            rd_en   <= 1'b1;
            rd_addr <= '0;
          end
        end

        S_RUN: begin
          out_we <= 1'b0;
          case (phase)
            3'd0: begin
              rd_addr <= base + ONE_IN;
              phase   <= 3'd1;
            end
            3'd1: begin
              acc     <= rd_data;
              rd_addr <= base + ROW_OFS;
              phase   <= 3'd2;
            end
            3'd2: begin
              acc     <= acc | rd_data;
              rd_addr <= base + ROW_OFS + ONE_IN;
              phase   <= 3'd3;
            end
            3'd3: begin
              acc   <= acc | rd_data;
              rd_en <= 1'b0;
              phase <= 3'd4;
            end
            default: begin
              acc      <= acc | rd_data;
              out_we   <= 1'b1;
              out_din  <= acc | rd_data;
              out_addr <= wr_idx;
              wr_idx   <= wr_idx + OUT_AW'(1);
              phase    <= 3'd0;
              if (last_win) begin
                state <= S_FLUSH;
              end else begin
                rd_en   <= 1'b1;
                rd_addr <= next_base;
                base    <= next_base;
                if (col_wrap) begin
                  c <= '0;
                  if (row_wrap) begin
                    r <= '0;
                    k <= k + KW'(1);
                  end else begin
                    r <= r + CW'(1);
                  end
                end else begin
                  c <= c + CW'(1);
                end
              end
            end
          endcase
        end

        S_FLUSH: begin
          out_we <= 1'b0;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_DONE;
        end

        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pool_1.sv
// tb_pool_1: self-checking bench for pool_1 with a behavioural feature RAM
// and a reference model of 2x2 OR pooling computed directly from map indices.
module tb_pool_1;

  localparam int MAP_W   = 24;
  localparam int KERNELS = 6;
  localparam int HALF    = MAP_W / 2;
  localparam int N       = KERNELS * HALF * HALF;
  localparam int IN_N    = KERNELS * MAP_W * MAP_W;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic        rd_en;
  logic [14:0] rd_addr;
  logic        rd_data = 1'b0;
  logic        out_we;
  logic [12:0] out_addr;
  logic        out_din;

  pool_1 #(
    .MAP_W(MAP_W),
    .KERNELS(KERNELS),
    .IN_AW(15),
    .OUT_AW(13)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .busy(busy),
    .done(done),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .out_we(out_we),
    .out_addr(out_addr),
    .out_din(out_din)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit mem [IN_N];
  bit exp_out [N];

  // Feature RAM: one-cycle read latency; garbage when not enabled.
  always @(posedge clk) begin
    if (rd_en && int'(rd_addr) < IN_N) rd_data <= mem[int'(rd_addr)];
    else rd_data <= 1'($urandom);
  end

  int wq_addr[$];
  bit wq_din[$];
  int wq_cyc[$];
  int rq[$];
  int dq[$];
  int consec = 0;
  bit prev_we = 1'b0;

  // Observe the RAM ports away from the active edge.
  always @(negedge clk) begin
    if (out_we) begin
      wq_addr.push_back(int'(out_addr));
      wq_din.push_back(out_din);
      wq_cyc.push_back(cyc);
      if (prev_we) consec++;
    end
    prev_we = out_we;
    if (rd_en) rq.push_back(int'(rd_addr));
    if (done) dq.push_back(cyc);
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic clear_mon();
    wq_addr.delete();
    wq_din.delete();
    wq_cyc.delete();
    rq.delete();
    dq.delete();
    consec  = 0;
    prev_we = 1'b0;
  endtask

  // pat: 0 zeros, 1 single one at addr, 2 checkerboard, 3 sparse random, 4 dense random
  task automatic fill(input int pat, input int addr);
    for (int i = 0; i < IN_N; i++) begin
      int row, col;
      row = (i % (MAP_W * MAP_W)) / MAP_W;
      col = i % MAP_W;
      case (pat)
        0: mem[i] = 1'b0;
        1: mem[i] = (i == addr);
        2: mem[i] = 1'(((row + col) % 2) == 1);
        3: mem[i] = ($urandom_range(0, 15) == 0);
        default: mem[i] = 1'($urandom);
      endcase
    end
    for (int kk = 0; kk < KERNELS; kk++)
      for (int rr = 0; rr < HALF; rr++)
        for (int cc = 0; cc < HALF; cc++) begin
          int b;
          b = kk * MAP_W * MAP_W + 2 * rr * MAP_W + 2 * cc;
          exp_out[kk * HALF * HALF + rr * HALF + cc] =
            mem[b] | mem[b + 1] | mem[b + MAP_W] | mem[b + MAP_W + 1];
        end
  endtask

  task automatic run_pass(input string tag, input int extra_off, output int t_acc);
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    t_acc = cyc;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_rise"}, busy, 1);
    if (extra_off > 0) begin
      while (cyc < t_acc + extra_off) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    while (dq.size() == 0 && cyc < t_acc + 5 * N + 50) @(negedge clk);
    repeat (10) @(negedge clk);
  endtask

  task automatic check_pass(input string tag, input int t);
    int bad_addr, bad_din, bad_rd, nw;
    bad_addr = 0;
    bad_din  = 0;
    bad_rd   = 0;
    nw = (wq_addr.size() < N) ? wq_addr.size() : N;
    check({tag, "_nwrites"}, wq_addr.size(), N);
    for (int i = 0; i < nw; i++) begin
      if (wq_addr[i] != i) bad_addr++;
      if (wq_din[i] != exp_out[i]) bad_din++;
    end
    check({tag, "_out_addr_errs"}, bad_addr, 0);
    check({tag, "_out_din_errs"}, bad_din, 0);
    check({tag, "_nreads"}, rq.size(), 4 * N);
    for (int i = 0; i < rq.size() && i < 4 * N; i++) begin
      int w, kk, rr, cc, q, ea;
      w  = i / 4;
      q  = i % 4;
      kk = w / (HALF * HALF);
      rr = (w % (HALF * HALF)) / HALF;
      cc = w % HALF;
      ea = kk * MAP_W * MAP_W + 2 * rr * MAP_W + 2 * cc + (q % 2) + (q / 2) * MAP_W;
      if (rq[i] != ea) bad_rd++;
    end
    check({tag, "_rd_addr_errs"}, bad_rd, 0);
    if (wq_cyc.size() > 0) begin
      check({tag, "_first_we_cyc"}, wq_cyc[0] - t, 6);
      check({tag, "_last_we_cyc"}, wq_cyc[wq_cyc.size() - 1] - t, 1 + 5 * N);
    end
    check({tag, "_ndone"}, dq.size(), 1);
    if (dq.size() > 0) check({tag, "_done_cyc"}, dq[0] - t, 2 + 5 * N);
    check({tag, "_consec_we"}, consec, 0);
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  typedef struct {
    int pat;
    int addr;
    int exp_ones;
    int exp_one_idx;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int t, ones, one_idx, nw0;

    vecs[0] = '{pat: 0, addr: 0,    exp_ones: 0,  exp_one_idx: -1};
    vecs[1] = '{pat: 1, addr: 127,  exp_ones: 1,  exp_one_idx: 27};
    vecs[2] = '{pat: 1, addr: 3455, exp_ones: 1,  exp_one_idx: 863};
    vecs[3] = '{pat: 2, addr: 0,    exp_ones: N,  exp_one_idx: -1};
    vecs[4] = '{pat: 3, addr: 0,    exp_ones: -1, exp_one_idx: -1};

    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, rd_en, rd_addr, out_we, out_addr, out_din}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      fill(vecs[v].pat, vecs[v].addr);
      run_pass(tag, 0, t);
      check_pass(tag, t);
      ones = 0;
      one_idx = -1;
      foreach (wq_din[i]) if (wq_din[i]) begin
        ones++;
        if (one_idx < 0) one_idx = wq_addr[i];
      end
      if (vecs[v].exp_ones >= 0) check({tag, "_ones"}, ones, vecs[v].exp_ones);
      if (vecs[v].exp_one_idx >= 0) check({tag, "_one_idx"}, one_idx, vecs[v].exp_one_idx);
      if (vecs[v].pat == 2 && rq.size() >= 580) begin
        check("chk_win_k1_a0", rq[576], 576);
        check("chk_win_k1_a1", rq[577], 577);
        check("chk_win_k1_a2", rq[578], 600);
        check("chk_win_k1_a3", rq[579], 601);
      end
    end

    // start re-pulsed while running must not disturb the pass
    fill(4, 0);
    run_pass("restart", 100, t);
    check_pass("restart", t);

    // start coinciding with done must not launch a new pass
    fill(3, 0);
    run_pass("start_at_done", 2 + 5 * N, t);
    check_pass("start_at_done", t);

    // asynchronous reset in the middle of a pass
    fill(4, 0);
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    t = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t + 2001) @(negedge clk);
    check("pre_rst_rd_en", rd_en, 1);
    check("pre_rst_out_we", out_we, 1);
    rst_n = 1'b0;
    #1;
    check("rst_rd_en", rd_en, 0);
    check("rst_out_we", out_we, 0);
    check("rst_busy", busy, 0);
    nw0 = wq_addr.size();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_no_more_writes", wq_addr.size(), nw0);
    check("rst_stays_idle", busy, 0);

    fill(3, 0);
    run_pass("after_rst", 0, t);
    check_pass("after_rst", t);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
